// File: rtl/butterfly_stage_stream.sv
// Streaming radix-2 DIT butterfly: one complex butterfly per beat, two-stage pipeline with valid/ready.
// Optional sticky overflow reporting port ovf_flag is enabled by defining BFLY_STAGE_OVF_EN.
module butterfly_stage_stream #(
    parameter int N     = 8,
    parameter int Q     = 4,
    parameter int PAIRS = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_last,
    input  logic         scale,
    input  logic [N-1:0] a_r,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_r,
    input  logic [N-1:0] b_i,
    input  logic [N-1:0] tw_r,
    input  logic [N-1:0] tw_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic [N-1:0] y0_r,
    output logic [N-1:0] y0_i,
    output logic [N-1:0] y1_r,
    output logic [N-1:0] y1_i,
`ifdef BFLY_STAGE_OVF_EN
    output logic         ovf_flag,
`endif
    output logic         frame_err
);
    localparam int CW = (PAIRS > 2) ? $clog2(PAIRS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PAIRS - 1);
    localparam logic signed [N+1:0] SAT_HI = (N+2)'((1 << (N-1)) - 1);
    localparam logic signed [N+1:0] SAT_LO = ~SAT_HI;
    localparam logic signed [2*N:0] RND = (2*N+1)'(1 << (Q-1));

    logic          adv, accept, at_end, mismatch, beat_scale;
    logic [CW-1:0] cnt_reg;
    logic          scale_hold_reg;

    assign adv        = !out_valid || out_ready;
    assign in_ready   = adv;
    assign accept     = in_valid && adv;
    assign at_end     = (cnt_reg == CNT_LAST);
    assign mismatch   = (in_last != at_end);
    assign beat_scale = (cnt_reg == '0) ? scale : scale_hold_reg;

    // Frame tracking: a framing error restarts the count so the next beat opens a new frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg        <= '0;
            scale_hold_reg <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            frame_err <= accept && mismatch;
            if (accept) begin
                cnt_reg <= (mismatch || at_end) ? '0 : cnt_reg + CW'(1);
                if (cnt_reg == '0)
                    scale_hold_reg <= scale;
            end
        end
    end

    // Stage 1: the four partial products of W*b
    logic signed [2*N-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [2*N-1:0] p_rr_reg, p_ii_reg, p_ri_reg, p_ir_reg;
    logic signed [N-1:0]   s1_ar_reg, s1_ai_reg;
    logic                  s1_valid_reg, s1_last_reg, s1_scale_reg;

    assign p_rr = $signed(b_r) * $signed(tw_r);
    assign p_ii = $signed(b_i) * $signed(tw_i);
    assign p_ri = $signed(b_r) * $signed(tw_i);
    assign p_ir = $signed(b_i) * $signed(tw_r);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_scale_reg <= 1'b0;
            s1_ar_reg    <= '0;
            s1_ai_reg    <= '0;
            p_rr_reg     <= '0;
            p_ii_reg     <= '0;
            p_ri_reg     <= '0;
            p_ir_reg     <= '0;
        end else if (adv) begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_last_reg  <= at_end;
                s1_scale_reg <= beat_scale;
                s1_ar_reg    <= $signed(a_r);
                s1_ai_reg    <= $signed(a_i);
                p_rr_reg     <= p_rr;
                p_ii_reg     <= p_ii;
                p_ri_reg     <= p_ri;
                p_ir_reg     <= p_ir;
            end
        end
    end

    // Stage 2: twiddle rounding, sum/difference, optional halving, saturation
    logic signed [2*N:0] t_r_full, t_i_full, t_r_sh, t_i_sh;
    logic signed [N+1:0] t_r, t_i, a_r_x, a_i_x;
    logic signed [N+1:0] pre [4];
    logic signed [N-1:0] sat_val [4];
    logic [3:0]          sat_hit;

    assign t_r_full = p_rr_reg - p_ii_reg;
    assign t_i_full = p_ri_reg + p_ir_reg;
    assign t_r_sh   = (t_r_full + RND) >>> Q;
    assign t_i_sh   = (t_i_full + RND) >>> Q;
    assign t_r      = t_r_sh[N+1:0];
    assign t_i      = t_i_sh[N+1:0];
    assign a_r_x    = s1_ar_reg;
    assign a_i_x    = s1_ai_reg;
    assign pre[0]   = a_r_x + t_r;
    assign pre[1]   = a_i_x + t_i;
    assign pre[2]   = a_r_x - t_r;
    assign pre[3]   = a_i_x - t_i;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_comp
            logic signed [N+2:0] ext, halved;
            logic signed [N+1:0] scaled;
            assign ext    = pre[gi];
            assign halved = (ext + (N+3)'(1)) >>> 1;
            assign scaled = s1_scale_reg ? halved[N+1:0] : pre[gi];
            assign sat_hit[gi] = (scaled > SAT_HI) || (scaled < SAT_LO);
            assign sat_val[gi] = (scaled > SAT_HI) ? SAT_HI[N-1:0] :
                                 (scaled < SAT_LO) ? SAT_LO[N-1:0] : scaled[N-1:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            y0_r      <= '0;
            y0_i      <= '0;
            y1_r      <= '0;
            y1_i      <= '0;
        end else if (adv) begin
            out_valid <= s1_valid_reg;
            out_last  <= s1_valid_reg && s1_last_reg;
            if (s1_valid_reg) begin
                y0_r <= sat_val[0];
                y0_i <= sat_val[1];
                y1_r <= sat_val[2];
                y1_i <= sat_val[3];
            end
        end
    end

`ifdef BFLY_STAGE_OVF_EN
    // Sticky until the next frame opens; a saturating beat in the same cycle wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_flag <= 1'b0;
        end else begin
            if (accept && cnt_reg == '0)
                ovf_flag <= 1'b0;
            if (adv && s1_valid_reg && |sat_hit)
                ovf_flag <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_butterfly_stage_stream.sv
// Directed bench for butterfly_stage_stream: scoreboard of expected beats, checked as outputs are handshaken.
module tb_butterfly_stage_stream;
    localparam int N = 8;
    localparam int Q = 4;
    localparam int PAIRS = 16;

    logic clk, rst, in_valid, in_ready, in_last, scale, out_valid, out_ready, out_last, frame_err;
    logic [N-1:0] a_r, a_i, b_r, b_i, tw_r, tw_i, y0_r, y0_i, y1_r, y1_i;
`ifdef BFLY_STAGE_OVF_EN
    logic ovf_flag;
`endif

    butterfly_stage_stream #(.N(N), .Q(Q), .PAIRS(PAIRS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .scale(scale),
        .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i), .tw_r(tw_r), .tw_i(tw_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .y0_r(y0_r), .y0_i(y0_i), .y1_r(y1_r), .y1_i(y1_i),
`ifdef BFLY_STAGE_OVF_EN
        .ovf_flag(ovf_flag),
`endif
        .frame_err(frame_err)
    );

    typedef struct packed {
        logic [N-1:0] y0r, y0i, y1r, y1i;
        logic         last;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_cnt = 0;
    bit   m_hold = 0;
    bit   exp_err = 0;
    bit   acc_seen = 0;
    int   stall_cnt = 0;
    int   cur_ar, cur_ai, cur_br, cur_bi, cur_wr, cur_wi;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference butterfly arm computed on plain integers
    function automatic logic [N-1:0] arm(input int a, input int t, input bit minus, input bit sc);
        int y;
        y = minus ? a - t : a + t;
        if (sc) y = (y + 1) >>> 1;
        if (y > 127) y = 127;
        if (y < -128) y = -128;
        return y[N-1:0];
    endfunction

    task automatic model_accept();
        int  tr, ti;
        bit  at_end, sc;
        exp_t e;
        at_end = (m_cnt == PAIRS - 1);
        sc = (m_cnt == 0) ? scale : m_hold;
        if (m_cnt == 0) m_hold = scale;
        tr = (cur_br * cur_wr - cur_bi * cur_wi + (1 << (Q - 1))) >>> Q;
        ti = (cur_br * cur_wi + cur_bi * cur_wr + (1 << (Q - 1))) >>> Q;
        e.y0r  = arm(cur_ar, tr, 1'b0, sc);
        e.y0i  = arm(cur_ai, ti, 1'b0, sc);
        e.y1r  = arm(cur_ar, tr, 1'b1, sc);
        e.y1i  = arm(cur_ai, ti, 1'b1, sc);
        e.last = at_end;
        sb.push_back(e);
        exp_err = (in_last != at_end);
        m_cnt = (exp_err || at_end) ? 0 : m_cnt + 1;
    endtask

    // One clock cycle, entered and left just after a falling edge
    task automatic cycle();
        exp_t e;
        bit   acc;
        out_ready = (stall_cnt == 0);
        if (stall_cnt > 0) stall_cnt--;
        #1;
        check("frame_err", frame_err, exp_err);
        if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                e = sb.pop_front();
                $display("beat out: y0=(%0d,%0d) y1=(%0d,%0d) last=%0b", $signed(y0_r), $signed(y0_i),
                         $signed(y1_r), $signed(y1_i), out_last);
                check("y0_r", $signed(y0_r), $signed(e.y0r));
                check("y0_i", $signed(y0_i), $signed(e.y0i));
                check("y1_r", $signed(y1_r), $signed(e.y1r));
                check("y1_i", $signed(y1_i), $signed(e.y1i));
                check("out_last", out_last, e.last);
            end
        end
        acc = in_valid && in_ready;
        @(posedge clk);
        exp_err = 0;
        acc_seen = acc;
        if (acc) model_accept();
        @(negedge clk);
    endtask

    task automatic send_beat(input int ar, input int ai, input int br, input int bi,
                             input int wr, input int wi, input bit sc, input bit lst);
        int k;
        cur_ar = ar; cur_ai = ai; cur_br = br; cur_bi = bi; cur_wr = wr; cur_wi = wi;
        a_r = ar[N-1:0]; a_i = ai[N-1:0]; b_r = br[N-1:0]; b_i = bi[N-1:0];
        tw_r = wr[N-1:0]; tw_i = wi[N-1:0];
        scale = sc; in_last = lst; in_valid = 1'b1;
        k = 0;
        acc_seen = 0;
        while (!acc_seen && k < 100) begin
            cycle();
            k++;
        end
        if (!acc_seen) check("accept_timeout", 0, 1);
    endtask

    task automatic rand_beat(input bit sc, input bit lst);
        send_beat(int'($urandom_range(0, 200)) - 100, int'($urandom_range(0, 200)) - 100,
                  int'($urandom_range(0, 120)) - 60, int'($urandom_range(0, 120)) - 60,
                  int'($urandom_range(0, 32)) - 16, int'($urandom_range(0, 32)) - 16, sc, lst);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (n) cycle();
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; in_last = 0; scale = 0; out_ready = 1;
        a_r = 0; a_i = 0; b_r = 0; b_i = 0; tw_r = 0; tw_i = 0;
        #2 rst = 1'b0;
        @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_y0_r", y0_r, 0);
        check("rst_y1_i", y1_i, 0);
        @(negedge clk);
        rst = 1'b1;

        // Frame 1: directed vectors, a 5-cycle output stall at beat 6, last on beat 15
        send_beat(16, 0, 16, 0, 16, 0, 1'b0, 1'b0);
        send_beat(0, 0, 16, 0, 0, -16, 1'b1, 1'b0);
        send_beat(100, 0, 100, 0, 16, 0, 1'b1, 1'b0);
        for (int i = 3; i < PAIRS; i++) begin
            if (i == 6) stall_cnt = 5;
            rand_beat(1'b0, i == PAIRS - 1);
        end
        idle(4);
`ifdef BFLY_STAGE_OVF_EN
        check("ovf_flag_set", ovf_flag, 1);
`endif

        // Frame 2: halving sampled on the first beat, scale input ignored afterwards
        send_beat(100, 0, 100, 0, 16, 0, 1'b1, 1'b0);
        for (int i = 1; i < PAIRS; i++) rand_beat($urandom_range(0, 1) == 1, i == PAIRS - 1);

        // Early in_last on beat 3, then a full frame whose first beat resamples scale
        for (int i = 0; i < 4; i++) rand_beat(1'b0, i == 3);
        send_beat(100, 0, 100, 0, 16, 0, 1'b1, 1'b0);
        for (int i = 1; i < PAIRS; i++) rand_beat(1'b0, i == PAIRS - 1);

        // Missing in_last on beat 15
        for (int i = 0; i < PAIRS; i++) rand_beat(1'b0, 1'b0);
        idle(3);

        // Reset in the middle of a frame with beats still in flight
        for (int i = 0; i < 7; i++) rand_beat(1'b0, 1'b0);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_last", out_last, 0);
        sb.delete();
        m_cnt = 0; m_hold = 0; exp_err = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < PAIRS; i++) rand_beat(1'b1, i == PAIRS - 1);
        idle(6);
        check("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
